// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and defaults for the two-requester round-robin arbiter
// that owns the shared 4-bit MUXB path.
package mux_rr_arbiter_pkg;

   localparam int unsigned DATA_W        = 4;
   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned CNT_W_DEF     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } arb_state_e;

   // Grant state for a requester index.
   function automatic arb_state_e grant_state(input logic idx);
      return idx ? G1 : G0;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the two producers, the arbiter and the sink.
// The master modport is the producer/sink side; the slave modport is the arbiter.
interface mux_rr_arbiter_if;
   import mux_rr_arbiter_pkg::*;

   logic              req0;
   logic [DATA_W-1:0] d0;
   logic              req1;
   logic [DATA_W-1:0] d1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] y;
   logic              y_valid;
   logic              y_ready;
   logic              sel;

   modport master (
      output req0, d0, req1, d1, y_ready,
      input  ack0, ack1, y, y_valid, sel
   );

   modport slave (
      input  req0, d0, req1, d1, y_ready,
      output ack0, ack1, y, y_valid, sel
   );

endinterface

// File: rtl/mux_rr_arbiter_muxb.sv
// MUXB: the shared 4-bit 2:1 select mux (x=0 -> d0, x=1 -> d1).
module MUXB
   import mux_rr_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic              x,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = x ? d1 : d0;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two requesters sharing one MUXB path to a single sink,
// with bursts capped at MAX_BURST beats while the other side is waiting.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   mux_rr_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_last;
   logic              w_last_nxt;
   logic              r_sel;

   logic              w_own_req;
   logic              w_oth_req;
   logic              w_beat;
   logic              w_burst_end;
   logic              w_ack0;
   logic              w_ack1;
   logic              w_y_valid;
   logic [DATA_W-1:0] w_y;

   // sel is registered alongside the state so it always equals (state == G1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
         r_sel   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_sel   <= (w_state_nxt == G1);
      end
   end

   always_comb begin
      w_own_req = 1'b0;
      w_oth_req = 1'b0;
      case (r_state)
         G0: begin
            w_own_req = bus.req0;
            w_oth_req = bus.req1;
         end
         G1: begin
            w_own_req = bus.req1;
            w_oth_req = bus.req0;
         end
         default: begin
            w_own_req = 1'b0;
            w_oth_req = 1'b0;
         end
      endcase
      w_beat      = w_own_req & bus.y_ready;
      w_burst_end = w_beat & (r_cnt == LP_CNT_LAST);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (bus.req0 && bus.req1) begin
               w_state_nxt = grant_state(!r_last);
            end else if (bus.req0) begin
               w_state_nxt = G0;
            end else if (bus.req1) begin
               w_state_nxt = G1;
            end
         end
         G0, G1: begin
            if (w_beat) begin
               w_last_nxt = (r_state == G1);
            end
            // Dropping req (with or without a beat) hands straight over, no idle bubble.
            if (!w_own_req) begin
               w_cnt_nxt   = '0;
               w_state_nxt = w_oth_req ? grant_state(r_state == G0) : IDLE;
            end else if (w_burst_end) begin
               w_cnt_nxt = '0;
               if (w_oth_req) begin
                  w_state_nxt = grant_state(r_state == G0);
               end
            end else if (w_beat) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_y_valid = w_own_req;
      w_ack0    = (r_state == G0) & bus.req0 & bus.y_ready;
      w_ack1    = (r_state == G1) & bus.req1 & bus.y_ready;
   end

   MUXB u_muxb (
      .d0 (bus.d0),
      .d1 (bus.d1),
      .x  (r_sel),
      .y  (w_y)
   );

   assign bus.y       = w_y;
   assign bus.y_valid = w_y_valid;
   assign bus.ack0    = w_ack0;
   assign bus.ack1    = w_ack1;
   assign bus.sel     = r_sel;

   a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(w_ack0 && w_ack1));
   a_ack0_sel:      assert property (@(posedge clk) disable iff (!rst_n) w_ack0 |-> !r_sel);
   a_ack1_sel:      assert property (@(posedge clk) disable iff (!rst_n) w_ack1 |-> r_sel);
   a_idle_invalid:  assert property (@(posedge clk) disable iff (!rst_n) (r_state == IDLE) |-> !w_y_valid);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter (MAX_BURST=2): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against an ownership model.
module tb_mux_rr_arbiter;

   localparam int unsigned MB = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mux_rr_arbiter_if bus ();

   mux_rr_arbiter #(
      .MAX_BURST (MB),
      .CNT_W     (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   // Model: who owns the path, beats taken in the current tenure, who was served last.
   int          m_owner;
   int unsigned m_run;
   int          m_last;

   initial begin
      m_owner = -1;
      m_run   = 0;
      m_last  = 1;
   end

   always @(negedge clk) begin
      int r0, r1, rdy, me, mine, theirs;
      int e_valid, e_ack0, e_ack1, e_sel, e_y;
      if (!rst_n) begin
         m_owner = -1;
         m_run   = 0;
         m_last  = 1;
      end
      r0  = int'(bus.req0);
      r1  = int'(bus.req1);
      rdy = int'(bus.y_ready);
      e_sel   = (m_owner == 1) ? 1 : 0;
      e_valid = (m_owner == 0) ? r0 : ((m_owner == 1) ? r1 : 0);
      e_ack0  = (m_owner == 0 && r0 != 0 && rdy != 0) ? 1 : 0;
      e_ack1  = (m_owner == 1 && r1 != 0 && rdy != 0) ? 1 : 0;
      e_y     = (e_sel != 0) ? int'(bus.d1) : int'(bus.d0);
      check("model_y_valid", int'(bus.y_valid), e_valid);
      check("model_ack0",    int'(bus.ack0),    e_ack0);
      check("model_ack1",    int'(bus.ack1),    e_ack1);
      check("model_sel",     int'(bus.sel),     e_sel);
      check("model_y",       int'(bus.y),       e_y);
      if (rst_n) begin
         if (m_owner < 0) begin
            if (r0 != 0 && r1 != 0) m_owner = 1 - m_last;
            else if (r0 != 0)       m_owner = 0;
            else if (r1 != 0)       m_owner = 1;
            m_run = 0;
         end else begin
            me     = m_owner;
            mine   = (me == 1) ? r1 : r0;
            theirs = (me == 1) ? r0 : r1;
            if (mine == 0) begin
               m_owner = (theirs != 0) ? 1 - me : -1;
               m_run   = 0;
            end else if (rdy != 0) begin
               m_last = me;
               m_run++;
               if (m_run == MB) begin
                  m_run = 0;
                  if (theirs != 0) m_owner = 1 - me;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [7:0] pat;
      logic [7:0] exp_pat;
      logic       e;
      checks   = 0;
      failures = 0;
      rst_n       = 1'b0;
      bus.req0    = 1'b0;
      bus.req1    = 1'b0;
      bus.d0      = 4'h7;
      bus.d1      = 4'h9;
      bus.y_ready = 1'b0;

      // Reset values
      step();
      mid();
      check("rst_y_valid", int'(bus.y_valid), 0);
      check("rst_ack0",    int'(bus.ack0),    0);
      check("rst_ack1",    int'(bus.ack1),    0);
      check("rst_sel",     int'(bus.sel),     0);
      check("rst_y_is_d0", int'(bus.y),       7);
      step();
      rst_n = 1'b1;

      // Single requester
      bus.req0 = 1'b1; bus.d0 = 4'hA; bus.y_ready = 1'b1;
      mid();
      check("single_latency_no_valid", int'(bus.y_valid), 0);
      for (int k = 0; k < 3; k++) begin
         step(); mid();
         check("single_y_valid", int'(bus.y_valid), 1);
         check("single_sel",     int'(bus.sel),     0);
         check("single_y",       int'(bus.y),       10);
         check("single_ack0",    int'(bus.ack0),    1);
      end
      step(); bus.req0 = 1'b0;
      mid();
      check("single_drop_ack0", int'(bus.ack0), 0);
      step(); mid();
      check("single_idle_valid", int'(bus.y_valid), 0);
      check("single_idle_sel",   int'(bus.sel),     0);

      // Fresh reset so requester 0 wins the tie
      step(); rst_n = 1'b0;
      step(); rst_n = 1'b1;

      // Fair tie with MAX_BURST=2
      bus.d0 = 4'h3; bus.d1 = 4'hC; bus.req0 = 1'b1; bus.req1 = 1'b1;
      mid();
      pat     = '0;
      exp_pat = 8'b00110011;
      for (int k = 0; k < 8; k++) begin
         step(); mid();
         e   = exp_pat[7-k];
         pat = {pat[6:0], bus.ack1};
         check("tie_ack1", int'(bus.ack1), int'(e));
         check("tie_ack0", int'(bus.ack0), int'(!e));
         check("tie_y",    int'(bus.y),    e ? 12 : 3);
      end
      check("tie_ack1_pattern", int'(pat), int'(exp_pat));

      // Handover into G1 then backpressure with d1=5
      step(); bus.req0 = 1'b0; bus.d1 = 4'h5; bus.y_ready = 1'b0;
      mid();
      check("bp_pre_valid", int'(bus.y_valid), 0);
      check("bp_pre_sel",   int'(bus.sel),     0);
      for (int k = 0; k < 4; k++) begin
         step(); mid();
         check("bp_y_valid", int'(bus.y_valid), 1);
         check("bp_y",       int'(bus.y),       5);
         check("bp_ack1",    int'(bus.ack1),    0);
         check("bp_sel",     int'(bus.sel),     1);
      end
      step(); bus.y_ready = 1'b1; bus.req0 = 1'b1;
      mid();
      check("bp_release_ack1", int'(bus.ack1), 1);
      step(); mid();
      check("bp_cnt_frozen_ack1", int'(bus.ack1), 1);
      check("bp_cnt_frozen_sel",  int'(bus.sel),  1);
      step(); mid();
      check("bp_switch_sel",  int'(bus.sel),  0);
      check("bp_switch_ack0", int'(bus.ack0), 1);
      check("bp_switch_y",    int'(bus.y),    3);

      // Handover: req0 drops in G0 with req1 pending
      step(); bus.req0 = 1'b0;
      mid();
      check("ho_drop_valid", int'(bus.y_valid), 0);
      step(); mid();
      check("ho_sel",   int'(bus.sel),     1);
      check("ho_valid", int'(bus.y_valid), 1);

      // Burst limit with idle peer
      bus.d1 = 4'hE;
      for (int k = 0; k < 5; k++) begin
         step(); mid();
         check("solo_ack1", int'(bus.ack1), 1);
         check("solo_sel",  int'(bus.sel),  1);
      end

      // Reset mid-burst in G1
      step(); rst_n = 1'b0;
      #1;
      check("midrst_sel",   int'(bus.sel),     0);
      check("midrst_valid", int'(bus.y_valid), 0);
      check("midrst_ack0",  int'(bus.ack0),    0);
      check("midrst_ack1",  int'(bus.ack1),    0);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      step(); rst_n = 1'b1;
      mid();
      check("midrst_idle_valid", int'(bus.y_valid), 0);
      step(); mid();
      check("midrst_first_sel",  int'(bus.sel),  0);
      check("midrst_first_ack0", int'(bus.ack0), 1);
      check("midrst_first_ack1", int'(bus.ack1), 0);

      // Randomized traffic; data only changes while a source is not requesting
      for (int c = 0; c < 3000; c++) begin
         step();
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
         if ($urandom_range(0, 9) < 2) bus.req0 = ~bus.req0;
         if ($urandom_range(0, 9) < 2) bus.req1 = ~bus.req1;
         if (!bus.req0) bus.d0 = 4'($urandom);
         if (!bus.req1) bus.d1 = 4'($urandom);
         bus.y_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      rst_n = 1'b1;
      mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
